// File: rtl/mario_sprite_ctrl.sv
// Mario sprite animation sequencer and two-stage pixel pipeline.
// Optional macro MARIO_MIRROR_EN: left-facing frames via mirrored right-facing ROMs.
module mario_sprite_ctrl #(
   parameter int          SPR_W           = 20,
   parameter int          SPR_H           = 22,
   parameter int          FRAMES_PER_STEP = 6,
   parameter logic [11:0] TRANSPARENT     = 12'h808
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_tick,
   input  logic        moving,
   input  logic        dir_left,
   input  logic        airborne,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   input  logic [9:0]  MarioX,
   input  logic [9:0]  MarioY,
   output logic [8:0]  rom_addr,
   output logic [3:0]  rom_sel,
   input  logic [11:0] rom_color,
   output logic        pixel_on,
   output logic [11:0] pixel_color
);

   localparam int CW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(FRAMES_PER_STEP - 1);
   localparam logic [10:0]   W11      = 11'(SPR_W);
   localparam logic [10:0]   H11      = 11'(SPR_H);
   localparam logic [9:0]    W10      = 10'(SPR_W);

   typedef enum logic [1:0] {STAND, WALK, JUMP} state_t;

   state_t        state_q, state_d;
   logic [2:0]    frame_q, frame_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          dir_q, dir_d;

   logic [8:0]    rom_addr_q, rom_addr_d;
   logic          in_box_q, in_box_d;
   logic          pixel_on_q, pixel_on_d;
   logic [11:0]   pixel_color_q, pixel_color_d;

   logic [10:0]   x11, y11, mx11, my11;
   logic [9:0]    dx, dy, dx_sel;
   logic [8:0]    lin;
   logic          sel_dir;

   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      if (frame_tick) begin
         if (moving && !airborne) dir_d = dir_left;
         if (airborne) begin
            state_d = JUMP;
            frame_d = 3'd4;
            cnt_d   = '0;
         end else begin
            unique case (state_q)
               WALK: begin
                  if (!moving) begin
                     state_d = STAND;
                     frame_d = 3'd0;
                     cnt_d   = '0;
                  end else if (cnt_q == CNT_LAST) begin
                     cnt_d   = '0;
                     frame_d = (frame_q == 3'd3) ? 3'd1 : frame_q + 3'd1;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
               default: begin
                  // STAND and landing from JUMP both restart the walk cycle
                  cnt_d = '0;
                  if (moving) begin
                     state_d = WALK;
                     frame_d = 3'd1;
                  end else begin
                     state_d = STAND;
                     frame_d = 3'd0;
                  end
               end
            endcase
         end
      end
   end

   always_comb begin
      x11  = {1'b0, DrawX};
      y11  = {1'b0, DrawY};
      mx11 = {1'b0, MarioX};
      my11 = {1'b0, MarioY};
      in_box_d = (x11 >= mx11) && (x11 < mx11 + W11) &&
                 (y11 >= my11) && (y11 < my11 + H11);
      dx = DrawX - MarioX;
      dy = DrawY - MarioY;
`ifdef MARIO_MIRROR_EN
      // dir_d keeps the address consistent with the rom_sel loaded at this edge
      dx_sel  = dir_d ? (W10 - 10'd1 - dx) : dx;
      sel_dir = 1'b0;
`else
      dx_sel  = dx;
      sel_dir = dir_q;
`endif
      lin        = 9'(dy * W10 + dx_sel);
      rom_addr_d = in_box_d ? lin : 9'd0;
   end

   always_comb begin
      pixel_on_d    = in_box_q && (rom_color != TRANSPARENT);
      pixel_color_d = pixel_on_d ? rom_color : 12'h000;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q       <= STAND;
         frame_q       <= 3'd0;
         cnt_q         <= '0;
         dir_q         <= 1'b0;
         rom_addr_q    <= 9'd0;
         in_box_q      <= 1'b0;
         pixel_on_q    <= 1'b0;
         pixel_color_q <= 12'h000;
      end else begin
         state_q       <= state_d;
         frame_q       <= frame_d;
         cnt_q         <= cnt_d;
         dir_q         <= dir_d;
         rom_addr_q    <= rom_addr_d;
         in_box_q      <= in_box_d;
         pixel_on_q    <= pixel_on_d;
         pixel_color_q <= pixel_color_d;
      end
   end

   assign rom_addr    = rom_addr_q;
   assign rom_sel     = {sel_dir, frame_q};
   assign pixel_on    = pixel_on_q;
   assign pixel_color = pixel_color_q;

endmodule

// File: tb/tb_mario_sprite_ctrl.sv
// Directed self-checking bench for mario_sprite_ctrl.
// Expectations follow MARIO_MIRROR_EN when it is defined.
module tb_mario_sprite_ctrl;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        frame_tick = 1'b0;
   logic        moving = 1'b0;
   logic        dir_left = 1'b0;
   logic        airborne = 1'b0;
   logic [9:0]  DrawX = '0, DrawY = '0, MarioX = '0, MarioY = '0;
   logic [8:0]  rom_addr;
   logic [3:0]  rom_sel;
   logic [11:0] rom_color = 12'h000;
   logic        pixel_on;
   logic [11:0] pixel_color;

   int checks = 0;
   int failures = 0;

`ifdef MARIO_MIRROR_EN
   localparam bit MIRROR = 1'b1;
`else
   localparam bit MIRROR = 1'b0;
`endif

   mario_sprite_ctrl dut (
      .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
      .moving(moving), .dir_left(dir_left), .airborne(airborne),
      .DrawX(DrawX), .DrawY(DrawY), .MarioX(MarioX), .MarioY(MarioY),
      .rom_addr(rom_addr), .rom_sel(rom_sel), .rom_color(rom_color),
      .pixel_on(pixel_on), .pixel_color(pixel_color)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic ftick();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
   endtask

   initial begin
      step();
      step();
      Reset = 1'b0;
      chk("rst_addr", 32'(rom_addr), 32'd0);
      chk("rst_sel", 32'(rom_sel), 32'd0);
      chk("rst_pon", 32'(pixel_on), 32'd0);
      chk("rst_pcol", 32'(pixel_color), 32'd0);

      // walk cycle, 25 ticks
      moving = 1'b1;
      for (int i = 1; i <= 25; i++) begin
         ftick();
         chk($sformatf("walk%0d", i), 32'(rom_sel),
             32'(((i - 1) / 6) % 3 + 1));
      end

      // visible pixel while walking at frame 2
      MarioX = 10'd100; MarioY = 10'd50;
      DrawX = 10'd105;  DrawY = 10'd53;
      rom_color = 12'hF30;
      step();
      step();
      chk("pre_rst_pon", 32'(pixel_on), 32'd1);

      // reset mid-walk
      Reset = 1'b1;
      step();
      chk("mid_rst_sel", 32'(rom_sel), 32'd0);
      chk("mid_rst_pon", 32'(pixel_on), 32'd0);
      chk("mid_rst_addr", 32'(rom_addr), 32'd0);
      Reset = 1'b0;
      moving = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ftick();
         chk($sformatf("post_rst_sel%0d", i), 32'(rom_sel), 32'd0);
      end

      // address
      step();
      chk("addr65", 32'(rom_addr), 32'd65);
      DrawX = 10'd119; DrawY = 10'd71;
      step();
      chk("addr439", 32'(rom_addr), 32'd439);
      DrawX = 10'd120; DrawY = 10'd53;
      step();
      chk("edge_addr", 32'(rom_addr), 32'd0);
      step();
      chk("edge_pon", 32'(pixel_on), 32'd0);
      DrawX = 10'd100; DrawY = 10'd72;
      step();
      step();
      chk("edge_bot_pon", 32'(pixel_on), 32'd0);

      // no wrap near the right edge of the 10-bit range
      MarioX = 10'd1015;
      DrawY = 10'd50;
      for (int x = 0; x < 15; x++) begin
         DrawX = 10'(x);
         step();
         step();
         chk($sformatf("nowrap_x%0d", x), 32'(pixel_on), 32'd0);
      end
      DrawX = 10'd1020;
      step();
      chk("wrap_in_addr", 32'(rom_addr), 32'd5);
      step();
      chk("wrap_in_pon", 32'(pixel_on), 32'd1);

      // transparency and latency
      MarioX = 10'd100;
      DrawX = 10'd105; DrawY = 10'd53;
      rom_color = 12'h808;
      step();
      step();
      chk("trans_pon", 32'(pixel_on), 32'd0);
      chk("trans_pcol", 32'(pixel_color), 32'd0);
      rom_color = 12'hF30;
      DrawX = 10'd0;
      step();
      step();
      chk("lat_pre", 32'(pixel_on), 32'd0);
      DrawX = 10'd105;
      step();
      chk("lat_c1", 32'(pixel_on), 32'd0);
      step();
      chk("lat_c2_pon", 32'(pixel_on), 32'd1);
      chk("lat_c2_pcol", 32'(pixel_color), 32'hF30);

      // jump priority
      moving = 1'b1; airborne = 1'b1;
      ftick();
      chk("jump_sel", 32'(rom_sel), 32'd4);
      airborne = 1'b0;
      ftick();
      chk("land_sel", 32'(rom_sel), 32'd1);

      // mirror / left ROM set
      dir_left = 1'b1;
      DrawX = 10'd100; DrawY = 10'd50;
      ftick();
      step();
      chk("dir_addr", 32'(rom_addr), MIRROR ? 32'd19 : 32'd0);
      chk("dir_sel3", 32'(rom_sel[3]), MIRROR ? 32'd0 : 32'd1);
      moving = 1'b0; dir_left = 1'b0;
      ftick();
      chk("dir_hold", 32'(rom_sel), MIRROR ? 32'd0 : 32'd8);

      // consecutive frame ticks each count
      moving = 1'b1;
      frame_tick = 1'b1;
      for (int i = 0; i < 7; i++) step();
      frame_tick = 1'b0;
      chk("consec_sel", 32'(rom_sel), 32'd2);
      step();
      chk("consec_hold", 32'(rom_sel), 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
